sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Two-port arbiter sharing the single SRAM controller request port (req/ready/rd/addr/be/wr_data,
//  rd_data_vld/rd_data) between two requesters, e.g. the SRAM pattern tester and a host loader.
//  Multiplexes commands by round-robin grant with a burst limit.
//  Routes each read-data beat back to the issuing requester via an in-order tag FIFO.
// PARAMETERS
//  ADDR_W     18  SRAM word address width
//  DATA_W     16  SRAM data width (BE_W = DATA_W/8)
//  BURST_MAX  8   max consecutive accepted commands for one port while the other port waits
//  TAG_DEPTH  4   outstanding-read capacity (power of 2, >=2)
// PORTS
//  clk             in   1       clock
//  reset_          in   1       asynchronous active-low reset
//  mN_req          in   1       N=0,1: command valid, held until mN_ready
//  mN_ready        out  1       command accepted this cycle (mN_req && granted && ram_ready && !stall)
//  mN_rd           in   1       1=read, 0=write
//  mN_addr         in   ADDR_W  word address
//  mN_be           in   BE_W    byte enables (writes)
//  mN_wr_data      in   DATA_W  write data
//  mN_rd_data_vld  out  1       read beat for port N
//  mN_rd_data      out  DATA_W  read data (ram_rd_data broadcast to both ports)
//  ram_req         out  1       to SRAM controller
//  ram_ready       in   1       controller accepts command
//  ram_rd/ram_addr/ram_be/ram_wr_data  out  1/ADDR_W/BE_W/DATA_W  granted port's command fields
//  ram_rd_data_vld in   1       read beat from controller, in command order
//  ram_rd_data     in   DATA_W  read data
//  arb_err         out  1       sticky: ram_rd_data_vld arrived with tag FIFO empty
// BEHAVIOUR
//  Reset: grant=0, burst_cnt=0, tag FIFO empty, arb_err=0. All outputs 0 except data buses
//   pass through (ram_addr etc. = port-0 fields, mN_rd_data = ram_rd_data).
//  Command path combinational: ram_{rd,addr,be,wr_data} = fields of port[grant];
//   ram_req = mN_req[grant] && !stall; stall = mN_rd[grant] && fifo_full && !pop.
//  Accept = ram_req && ram_ready; mN_ready[grant] = ram_ready && ram_req; other port's ready = 0.
//   Zero added latency; pipeline fully per cycle.
//  Grant update (registered, end of cycle):
//   - granted port req=0 and other req=1 -> switch, burst_cnt=0.
//   - accept and other req=1 and burst_cnt==BURST_MAX-1 -> switch, burst_cnt=0.
//   - accept otherwise -> burst_cnt++ (saturating at BURST_MAX-1); no accept -> hold.
//   - Never switch in a cycle where granted req=1 and no accept (command stays stable).
//  Tag FIFO: push grant id on accepted read; pop on ram_rd_data_vld; route vld to mN where
//   N = FIFO head. Push+pop same cycle legal at full (count unchanged) and empty (pop only if
//   head valid at cycle start; push visible next cycle).
//  rd_data_vld with empty FIFO: no mN_rd_data_vld, arb_err set until reset.
//  Writes never enter the FIFO and never stall on fifo_full.
//  Reset mid-operation: grant, counters and FIFO cleared asynchronously; outstanding tags lost;
//   controller must be reset together.
// CONFIGURATION
//  SRAM_ARB_FIXED_PRIO_EN defined: port 0 strict priority; at each grant update decision port 0
//   wins when m0_req=1 (burst limit ignored for port 0; port 1 loses grant whenever m0_req=1
//   and port 1 not mid-stall). Undefined (default): round-robin with BURST_MAX as above.
// STRUCTURE
//  Shared package sram_pkg: ADDR_W/DATA_W/BE_W constants, port-id type (1 bit), command struct
//   {rd, addr, be, wr_data}.
//  Sub-module sram_arb_tag_fifo: TAG_DEPTH x 1-bit sync FIFO with full/empty/count, async reset.
// TESTING
//  1. m0 only, 4 writes addr 0..3 with ram_ready=1 -> 4 back-to-back accepts, m1_ready=0, grant 0.
//  2. both req continuously, writes, BURST_MAX=8 -> grant pattern 8xP0, 8xP1, 8xP0; no idle cycle.
//  3. m0 read 0x10, m1 read 0x20, controller returns 0xAAAA then 0x5555 3 cycles later ->
//     m0_rd_data_vld with 0xAAAA, then m1_rd_data_vld with 0x5555.
//  4. TAG_DEPTH=4, 5 reads with no return -> 5th stalls (ram_req=0); vld pop same cycle -> accepted.
//  5. ram_rd_data_vld pulse with no reads issued -> no mN vld, arb_err=1 held; reset_ low clears it.
//  6. SRAM_ARB_FIXED_PRIO_EN, both req continuously -> port 0 granted every cycle, m1_ready=0.

Source files
------------

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the SRAM request-port arbiter.
//   ADDR_W / DATA_W / BE_W : SRAM word address, data and byte-enable widths
//   port_id_t              : requester identifier (0 or 1)
//   sram_cmd_t             : one command as presented on a request port
// -----------------------------------------------------------------------------
package sram_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int BE_W   = DATA_W / 8;

    // One bit is enough to name either requester.
    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    typedef struct packed {
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wr_data;
    } sram_cmd_t;

    // Identifier of the requester that is not p.
    function automatic port_id_t other_port(input port_id_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/sram_arb_tag_fifo.sv
// -----------------------------------------------------------------------------
// sram_arb_tag_fifo
// DEPTH x 1-bit synchronous FIFO holding the requester id of every read that
// the SRAM controller has accepted but not yet answered.  Beats come back in
// command order, so the head entry always names the owner of the next beat.
//
// Ports
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset (empties the FIFO)
//   push      in   write push_tag (ignored when full unless popping too)
//   push_tag  in   requester id to store
//   pop       in   drop the head entry (ignored when empty)
//   head_tag  out  requester id at the head
//   full      out  DEPTH entries stored
//   empty     out  no entries stored
//   count     out  number of stored entries
//
// Push and pop together are legal at full (count unchanged: the slot being
// written is the one being read, and the read is combinational from the
// current contents).  At empty, only the push takes effect.
// -----------------------------------------------------------------------------
module sram_arb_tag_fifo
    import sram_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  port_id_t         push_tag,
    input  logic             pop,
    output port_id_t         head_tag,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] mem_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against the occupancy at the start of the cycle.
    always_comb begin
        do_pop_s  = pop && (count_r != CNT_W'(0));
        do_push_s = push && ((count_r != CNT_W'(DEPTH)) || do_pop_s);
    end

    // Storage, pointers and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r    <= {DEPTH{1'b0}};
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_tag;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Status outputs.
    always_comb begin
        head_tag = mem_r[rd_ptr_r];
        full     = (count_r == CNT_W'(DEPTH));
        empty    = (count_r == CNT_W'(0));
        count    = count_r;
    end

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares the single SRAM controller request port between two requesters
// (e.g. the pattern tester and a host loader).  Commands from the granted port
// pass straight through with no added latency; the grant moves round-robin
// with a burst limit.  Every accepted read records its requester in a tag FIFO
// so the in-order read beats can be steered back to their owner.
//
// Ports (N = 0,1)
//   clk, reset_                     clock, asynchronous active-low reset
//   mN_req/rd/addr/be/wr_data   in  requester command, held until mN_ready
//   mN_ready                    out command accepted this cycle
//   mN_rd_data_vld              out read beat belongs to port N
//   mN_rd_data                  out read data (ram_rd_data broadcast)
//   ram_req/rd/addr/be/wr_data  out command to SRAM controller
//   ram_ready                   in  controller accepts command
//   ram_rd_data_vld/ram_rd_data in  read beat from controller, command order
//   arb_err                     out sticky: read beat arrived with no tag
//
// Build option
//   SRAM_ARB_FIXED_PRIO_EN : port 0 gets strict priority instead of
//                            round-robin; the burst limit no longer applies.
// -----------------------------------------------------------------------------
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int BURST_MAX = 8,
    parameter int TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              m0_req,
    output logic              m0_ready,
    input  logic              m0_rd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [BE_W-1:0]   m0_be,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_rd_data_vld,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_req,
    output logic              m1_ready,
    input  logic              m1_rd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [BE_W-1:0]   m1_be,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_rd_data_vld,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              ram_req,
    input  logic              ram_ready,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [BE_W-1:0]   ram_be,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic              ram_rd_data_vld,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              arb_err
);

    localparam int BC_W   = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam int TCNT_W = $clog2(TAG_DEPTH) + 1;
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_MAX - 1);

    // Burst counter increment that sticks at the last slot of a burst.
    function automatic logic [BC_W-1:0] burst_inc(input logic [BC_W-1:0] cnt);
        if (cnt == BURST_LAST) begin
            return cnt;
        end else begin
            return cnt + BC_W'(1);
        end
    endfunction

    port_id_t          grant_r;
    port_id_t          grant_nxt_s;
    logic [BC_W-1:0]   burst_cnt_r;
    logic [BC_W-1:0]   burst_cnt_nxt_s;
    logic              arb_err_r;

    sram_cmd_t         cmd0_s;
    sram_cmd_t         cmd1_s;
    sram_cmd_t         cmd_g_s;
    logic              req_g_s;
    logic              req_o_s;
    logic              pop_s;
    logic              stall_s;
    logic              ram_req_s;
    logic              accept_s;
    logic              push_s;

    port_id_t          head_tag_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [TCNT_W-1:0] fifo_count_s;

    sram_arb_tag_fifo #(
        .DEPTH    (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (reset_),
        .push     (push_s),
        .push_tag (grant_r),
        .pop      (pop_s),
        .head_tag (head_tag_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .count    (fifo_count_s)
    );

    // Command select and handshake.  A read to a full tag FIFO stalls unless
    // a beat is retiring a tag in the same cycle; writes never stall.
    always_comb begin
        cmd0_s = '{rd: m0_rd, addr: m0_addr, be: m0_be, wr_data: m0_wr_data};
        cmd1_s = '{rd: m1_rd, addr: m1_addr, be: m1_be, wr_data: m1_wr_data};
        if (grant_r == PORT1) begin
            cmd_g_s = cmd1_s;
            req_g_s = m1_req;
            req_o_s = m0_req;
        end else begin
            cmd_g_s = cmd0_s;
            req_g_s = m0_req;
            req_o_s = m1_req;
        end
        pop_s     = ram_rd_data_vld && (fifo_count_s != TCNT_W'(0));
        stall_s   = cmd_g_s.rd && fifo_full_s && !pop_s;
        ram_req_s = req_g_s && !stall_s;
        accept_s  = ram_req_s && ram_ready;
        push_s    = accept_s && cmd_g_s.rd;
    end

    // Grant state register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            grant_r     <= PORT0;
            burst_cnt_r <= BC_W'(0);
        end else begin
            grant_r     <= grant_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
        end
    end

    // Next-grant decision.  The grant never moves while the granted port
    // holds an unaccepted command, so that command stays stable.
    always_comb begin
        grant_nxt_s     = grant_r;
        burst_cnt_nxt_s = burst_cnt_r;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        if (grant_r == PORT0) begin
            if (!m0_req && m1_req) begin
                grant_nxt_s     = PORT1;
                burst_cnt_nxt_s = BC_W'(0);
            end else if (accept_s) begin
                burst_cnt_nxt_s = burst_inc(burst_cnt_r);
            end else begin
                grant_nxt_s     = grant_r;
            end
        end else begin
            // Port 1 yields to port 0 unless it is holding an unaccepted command.
            if (m0_req && (!m1_req || accept_s)) begin
                grant_nxt_s     = PORT0;
                burst_cnt_nxt_s = BC_W'(0);
            end else if (accept_s) begin
                burst_cnt_nxt_s = burst_inc(burst_cnt_r);
            end else begin
                grant_nxt_s     = grant_r;
            end
        end
`else
        if (!req_g_s && req_o_s) begin
            grant_nxt_s     = other_port(grant_r);
            burst_cnt_nxt_s = BC_W'(0);
        end else if (accept_s && req_o_s && (burst_cnt_r == BURST_LAST)) begin
            grant_nxt_s     = other_port(grant_r);
            burst_cnt_nxt_s = BC_W'(0);
        end else if (accept_s) begin
            burst_cnt_nxt_s = burst_inc(burst_cnt_r);
        end else begin
            grant_nxt_s     = grant_r;
        end
`endif
    end

    // Sticky error: a read beat with no outstanding tag to route it.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            arb_err_r <= 1'b0;
        end else if (ram_rd_data_vld && fifo_empty_s) begin
            arb_err_r <= 1'b1;
        end else begin
            arb_err_r <= arb_err_r;
        end
    end

    // Port-side and controller-side outputs.
    always_comb begin
        ram_req        = ram_req_s;
        ram_rd         = cmd_g_s.rd;
        ram_addr       = cmd_g_s.addr;
        ram_be         = cmd_g_s.be;
        ram_wr_data    = cmd_g_s.wr_data;
        m0_ready       = accept_s && (grant_r == PORT0);
        m1_ready       = accept_s && (grant_r == PORT1);
        m0_rd_data_vld = pop_s && (head_tag_s == PORT0);
        m1_rd_data_vld = pop_s && (head_tag_s == PORT1);
        m0_rd_data     = ram_rd_data;
        m1_rd_data     = ram_rd_data;
        arb_err        = arb_err_r;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Self-checking bench for sram_arbiter (BURST_MAX=8, TAG_DEPTH=4).
// Accepted commands and read beats are checked against expectation queues;
// single-cycle handshake behaviour is checked from a vector table.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;
    import sram_pkg::*;

    logic              clk = 1'b0;
    logic              reset_;
    logic              m0_req, m0_ready, m0_rd, m0_rd_data_vld;
    logic [ADDR_W-1:0] m0_addr;
    logic [BE_W-1:0]   m0_be;
    logic [DATA_W-1:0] m0_wr_data, m0_rd_data;
    logic              m1_req, m1_ready, m1_rd, m1_rd_data_vld;
    logic [ADDR_W-1:0] m1_addr;
    logic [BE_W-1:0]   m1_be;
    logic [DATA_W-1:0] m1_wr_data, m1_rd_data;
    logic              ram_req, ram_ready, ram_rd, ram_rd_data_vld, arb_err;
    logic [ADDR_W-1:0] ram_addr;
    logic [BE_W-1:0]   ram_be;
    logic [DATA_W-1:0] ram_wr_data, ram_rd_data;

    sram_arbiter #(.BURST_MAX(8), .TAG_DEPTH(4)) dut (
        .clk(clk), .reset_(reset_),
        .m0_req(m0_req), .m0_ready(m0_ready), .m0_rd(m0_rd), .m0_addr(m0_addr),
        .m0_be(m0_be), .m0_wr_data(m0_wr_data), .m0_rd_data_vld(m0_rd_data_vld),
        .m0_rd_data(m0_rd_data),
        .m1_req(m1_req), .m1_ready(m1_ready), .m1_rd(m1_rd), .m1_addr(m1_addr),
        .m1_be(m1_be), .m1_wr_data(m1_wr_data), .m1_rd_data_vld(m1_rd_data_vld),
        .m1_rd_data(m1_rd_data),
        .ram_req(ram_req), .ram_ready(ram_ready), .ram_rd(ram_rd), .ram_addr(ram_addr),
        .ram_be(ram_be), .ram_wr_data(ram_wr_data), .ram_rd_data_vld(ram_rd_data_vld),
        .ram_rd_data(ram_rd_data), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic              port;
        logic [ADDR_W-1:0] addr;
        logic              rd;
        logic [DATA_W-1:0] wdata;
    } cmd_exp_t;

    typedef struct {
        logic              port;
        logic [DATA_W-1:0] data;
    } rd_exp_t;

    typedef struct {
        logic m0_req, m1_req, ram_ready;
        logic exp_ram_req, exp_m0_ready, exp_m1_ready, exp_sel;
    } vec_t;

    cmd_exp_t cmd_q[$];
    rd_exp_t  rd_q[$];
    logic     acc0, acc1;
    vec_t     vecs[8];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic void push_cmd(input logic p, input logic [ADDR_W-1:0] a,
                                     input logic r, input logic [DATA_W-1:0] d);
        cmd_exp_t c;
        c.port = p; c.addr = a; c.rd = r; c.wdata = d;
        cmd_q.push_back(c);
    endfunction

    function automatic void push_rd(input logic p, input logic [DATA_W-1:0] d);
        rd_exp_t r;
        r.port = p; r.data = d;
        rd_q.push_back(r);
    endfunction

    task automatic idle();
        m0_req = 1'b0; m0_rd = 1'b0; m0_addr = 18'h00155; m0_be = 2'b01; m0_wr_data = 16'hA0A0;
        m1_req = 1'b0; m1_rd = 1'b0; m1_addr = 18'h002AA; m1_be = 2'b10; m1_wr_data = 16'hB1B1;
        ram_ready = 1'b1; ram_rd_data_vld = 1'b0; ram_rd_data = 16'h0000;
    endtask

    // Called just after a negedge with inputs driven; samples mid-cycle,
    // scores accepts and read beats, returns at the next negedge.
    task automatic cycle();
        cmd_exp_t c;
        rd_exp_t  r;
        #2;
        acc0 = m0_ready;
        acc1 = m1_ready;
        if (m0_ready || m1_ready || (ram_req && ram_ready)) begin
            check("acc_handshake", 32'(m0_ready | m1_ready), 32'(ram_req & ram_ready));
            check("acc_one_port", 32'(m0_ready & m1_ready), 32'd0);
            if (cmd_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_accept: got addr %0h want no accept", ram_addr);
            end else begin
                c = cmd_q.pop_front();
                check("acc_port", 32'(m1_ready), 32'(c.port));
                check("acc_addr", 32'(ram_addr), 32'(c.addr));
                check("acc_rd", 32'(ram_rd), 32'(c.rd));
                if (!c.rd) check("acc_wdata", 32'(ram_wr_data), 32'(c.wdata));
            end
        end
        if (m0_rd_data_vld || m1_rd_data_vld) begin
            check("vld_one_port", 32'(m0_rd_data_vld & m1_rd_data_vld), 32'd0);
            if (rd_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_beat: got vld %0b%0b want none", m1_rd_data_vld, m0_rd_data_vld);
            end else begin
                r = rd_q.pop_front();
                check("beat_port", 32'(m1_rd_data_vld), 32'(r.port));
                check("beat_data", 32'(m1_rd_data_vld ? m1_rd_data : m0_rd_data), 32'(r.data));
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset_ = 1'b0;
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  a0, a1;
        logic done0, done1;

        // ---------------- reset state ----------------
        idle();
        ram_rd_data = 16'hBEEF;
        reset_ = 1'b0;
        #3;
        check("rst_ram_req", 32'(ram_req), 32'd0);
        check("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
        check("rst_vld", 32'({m1_rd_data_vld, m0_rd_data_vld}), 32'd0);
        check("rst_arb_err", 32'(arb_err), 32'd0);
        check("rst_addr_p0", 32'(ram_addr), 32'h155);
        check("rst_rd_data0", 32'(m0_rd_data), 32'hBEEF);
        check("rst_rd_data1", 32'(m1_rd_data), 32'hBEEF);
        @(negedge clk);
        reset_ = 1'b1;
        idle();

        // ---------------- handshake vector table ----------------
        //            m0  m1  rdy  ram_req r0  r1  sel
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            m0_req = vecs[i].m0_req;
            m1_req = vecs[i].m1_req;
            ram_ready = vecs[i].ram_ready;
            if (vecs[i].exp_m0_ready) push_cmd(1'b0, 18'h00155, 1'b0, 16'hA0A0);
            if (vecs[i].exp_m1_ready) push_cmd(1'b1, 18'h002AA, 1'b0, 16'hB1B1);
            #1;
            check("vec_ram_req", 32'(ram_req), 32'(vecs[i].exp_ram_req));
            check("vec_m0_ready", 32'(m0_ready), 32'(vecs[i].exp_m0_ready));
            check("vec_m1_ready", 32'(m1_ready), 32'(vecs[i].exp_m1_ready));
            check("vec_addr", 32'(ram_addr), vecs[i].exp_sel ? 32'h2AA : 32'h155);
            check("vec_be", 32'(ram_be), vecs[i].exp_sel ? 32'd2 : 32'd1);
            cycle();
        end
        idle();

        // ---------------- 1: m0 only, 4 back-to-back writes ----------------
        do_reset();
        for (int i = 0; i < 4; i++) push_cmd(1'b0, ADDR_W'(i), 1'b0, DATA_W'(16'h1000 + i));
        for (int i = 0; i < 4; i++) begin
            m0_req = 1'b1; m0_addr = ADDR_W'(i); m0_wr_data = DATA_W'(16'h1000 + i);
            #1;
            check("t1_ram_req", 32'(ram_req), 32'd1);
            check("t1_m1_ready", 32'(m1_ready), 32'd0);
            cycle();
            check("t1_b2b", 32'(acc0), 32'd1);
        end
        idle();

`ifdef SRAM_ARB_FIXED_PRIO_EN
        // ---------------- 6: strict priority, both requesting ----------------
        do_reset();
        a0 = 0;
        for (int i = 0; i < 16; i++) push_cmd(1'b0, ADDR_W'(i), 1'b0, DATA_W'(16'h2000 + i));
        for (int i = 0; i < 16; i++) begin
            m0_req = 1'b1; m0_addr = ADDR_W'(a0); m0_wr_data = DATA_W'(16'h2000 + a0);
            m1_req = 1'b1; m1_addr = 18'h00100; m1_wr_data = 16'h3000;
            cycle();
            check("t6_m1_ready", 32'(acc1), 32'd0);
            if (acc0) a0++;
        end
        check("t6_accepts", 32'(a0), 32'd16);
        idle();
`else
        // ---------------- 2: round-robin with burst limit ----------------
        do_reset();
        a0 = 0; a1 = 0;
        for (int i = 0; i < 8; i++)  push_cmd(1'b0, ADDR_W'(i), 1'b0, DATA_W'(16'h2000 + i));
        for (int i = 0; i < 8; i++)  push_cmd(1'b1, ADDR_W'(16'h100 + i), 1'b0, DATA_W'(16'h3000 + i));
        for (int i = 8; i < 16; i++) push_cmd(1'b0, ADDR_W'(i), 1'b0, DATA_W'(16'h2000 + i));
        for (int i = 0; i < 24; i++) begin
            m0_req = 1'b1; m0_addr = ADDR_W'(a0); m0_wr_data = DATA_W'(16'h2000 + a0);
            m1_req = 1'b1; m1_addr = ADDR_W'(16'h100 + a1); m1_wr_data = DATA_W'(16'h3000 + a1);
            cycle();
            check("t2_no_idle", 32'(acc0 | acc1), 32'd1);
            if (acc0) a0++;
            if (acc1) a1++;
        end
        check("t2_accepts", 32'(a0 + a1), 32'd24);
        idle();
`endif

        // ---------------- 3: read routing ----------------
        do_reset();
        push_cmd(1'b0, 18'h00010, 1'b1, 16'h0000);
        push_cmd(1'b1, 18'h00020, 1'b1, 16'h0000);
        done0 = 1'b0; done1 = 1'b0;
        for (int i = 0; i < 6 && !(done0 && done1); i++) begin
            m0_req = !done0; m0_rd = 1'b1; m0_addr = 18'h00010;
            m1_req = !done1; m1_rd = 1'b1; m1_addr = 18'h00020;
            cycle();
            if (acc0) done0 = 1'b1;
            if (acc1) done1 = 1'b1;
        end
        idle();
        check("t3_issued", 32'({done1, done0}), 32'd3);
        cycle();
        cycle();
        push_rd(1'b0, 16'hAAAA);
        ram_rd_data_vld = 1'b1; ram_rd_data = 16'hAAAA;
        #1;
        check("t3_m1_quiet", 32'(m1_rd_data_vld), 32'd0);
        cycle();
        ram_rd_data_vld = 1'b0;
        cycle();
        cycle();
        push_rd(1'b1, 16'h5555);
        ram_rd_data_vld = 1'b1; ram_rd_data = 16'h5555;
        #1;
        check("t3_m0_quiet", 32'(m0_rd_data_vld), 32'd0);
        cycle();
        idle();
        check("t3_beats_done", 32'(rd_q.size()), 32'd0);

        // ---------------- 4: tag FIFO full stalls reads ----------------
        do_reset();
        for (int i = 0; i < 5; i++) push_cmd(1'b0, ADDR_W'(16'h30 + i), 1'b1, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            m0_req = 1'b1; m0_rd = 1'b1; m0_addr = ADDR_W'(16'h30 + i);
            cycle();
            check("t4_accept", 32'(acc0), 32'd1);
        end
        m0_addr = 18'h00034;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t4_stall_req", 32'(ram_req), 32'd0);
            check("t4_stall_ready", 32'(m0_ready), 32'd0);
            cycle();
        end
        push_rd(1'b0, 16'h1230);
        ram_rd_data_vld = 1'b1; ram_rd_data = 16'h1230;
        #1;
        check("t4_pop_accept", 32'(ram_req), 32'd1);
        cycle();
        check("t4_5th_taken", 32'(acc0), 32'd1);
        m0_req = 1'b0;
        for (int i = 1; i < 5; i++) begin
            push_rd(1'b0, DATA_W'(16'h1230 + i));
            ram_rd_data = DATA_W'(16'h1230 + i);
            cycle();
        end
        idle();
        check("t4_beats_done", 32'(rd_q.size()), 32'd0);

        // ---------------- 5: stray beat sets sticky error ----------------
        do_reset();
        ram_rd_data_vld = 1'b1; ram_rd_data = 16'h7777;
        #1;
        check("t5_no_vld", 32'({m1_rd_data_vld, m0_rd_data_vld}), 32'd0);
        check("t5_err_pre", 32'(arb_err), 32'd0);
        cycle();
        ram_rd_data_vld = 1'b0;
        #1;
        check("t5_err_set", 32'(arb_err), 32'd1);
        cycle();
        cycle();
        check("t5_err_sticky", 32'(arb_err), 32'd1);
        reset_ = 1'b0;
        #1;
        check("t5_err_reset", 32'(arb_err), 32'd0);
        @(negedge clk);
        reset_ = 1'b1;

        check("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
